// File: rtl/display_pkg.sv
// Shared constants for the seven-segment readback monitor: active-low segment
// codes (bit6=a ... bit0=g) and the capture FSM state type.
package display_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b1100000;
    localparam logic [6:0] SEG_C     = 7'b0110001;
    localparam logic [6:0] SEG_D     = 7'b1000010;
    localparam logic [6:0] SEG_E     = 7'b0110000;
    localparam logic [6:0] SEG_F     = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {
        S_ESPERA,
        S_CAPTURA,
        S_RETENIDO
    } estado_t;

endpackage

// File: rtl/segmentos_a_hex.sv
// Combinational cathode decoder: maps an active-low 7-segment pattern back to
// its hex value. coincide=1 for any of the 16 hex glyphs, blanco=1 for all-off.
module segmentos_a_hex
    import display_pkg::*;
(
    input  logic [6:0] catodos,
    output logic [3:0] valor,
    output logic       coincide,
    output logic       blanco
);

    // Reverse lookup of the hex glyph table
    always_comb begin
        valor    = '0;
        coincide = 1'b1;
        blanco   = 1'b0;
        case (catodos)
            SEG_0:     valor = 4'h0;
            SEG_1:     valor = 4'h1;
            SEG_2:     valor = 4'h2;
            SEG_3:     valor = 4'h3;
            SEG_4:     valor = 4'h4;
            SEG_5:     valor = 4'h5;
            SEG_6:     valor = 4'h6;
            SEG_7:     valor = 4'h7;
            SEG_8:     valor = 4'h8;
            SEG_9:     valor = 4'h9;
            SEG_A:     valor = 4'hA;
            SEG_B:     valor = 4'hB;
            SEG_C:     valor = 4'hC;
            SEG_D:     valor = 4'hD;
            SEG_E:     valor = 4'hE;
            SEG_F:     valor = 4'hF;
            SEG_BLANK: begin
                coincide = 1'b0;
                blanco   = 1'b1;
            end
            default:   coincide = 1'b0;
        endcase
    end

endmodule

// File: rtl/display_decodificador.sv
// Seven-segment display readback monitor. Samples the multiplexed active-low
// anode/cathode bus, waits for a pattern to be stable for STABLE_CYCLES
// consecutive samples, then captures it once into the per-digit register file.
// Build option: DISPLAY_SYNC_EN adds a 2-flop input synchronizer (latency
// STABLE_CYCLES+3); without it the bus is registered once (STABLE_CYCLES+2).
module display_decodificador
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              catodos_i,
    input  logic [N_DIGITS-1:0]     an_i,
    output logic [4*N_DIGITS-1:0]   digito_o,
    output logic [N_DIGITS-1:0]     valido_o,
    output logic                    nuevo_o,
    output logic                    error_o
);

    localparam int unsigned W  = N_DIGITS + 7;
    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [W-1:0]  muestra_d;
    logic [W-1:0]  muestra_q;
    logic          cambio;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    estado_t       estado;
    estado_t       estado_sig;

`ifdef DISPLAY_SYNC_EN
    logic [W-1:0] sync_meta;

    // First synchronizer stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_meta <= '0;
        else        sync_meta <= {an_i, catodos_i};
    end

    assign muestra_d = sync_meta;
`else
    assign muestra_d = {an_i, catodos_i};
`endif

    // Sample register holding the pattern under qualification
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) muestra_q <= '0;
        else        muestra_q <= muestra_d;
    end

    // Stability is judged on the value about to enter muestra_q versus the one
    // it holds, so qualification overlaps the final input stage.
    assign cambio = (muestra_d != muestra_q);

    // Saturating stability counter, cleared on any sample change
    always_comb begin
        cnt_next = cnt;
        if (cambio)              cnt_next = '0;
        else if (cnt != CNT_MAX) cnt_next = cnt + 1'b1;
    end

    // Stability counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else        cnt <= cnt_next;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) estado <= S_ESPERA;
        else        estado <= estado_sig;
    end

    // FSM next state: qualify, capture once, hold until the bus changes
    always_comb begin
        estado_sig = estado;
        case (estado)
            S_ESPERA:   if (cnt_next == CNT_MAX) estado_sig = S_CAPTURA;
            S_CAPTURA:  estado_sig = cambio ? S_ESPERA : S_RETENIDO;
            S_RETENIDO: if (cambio) estado_sig = S_ESPERA;
            default:    estado_sig = S_ESPERA;
        endcase
    end

    logic [N_DIGITS-1:0] an_q;
    logic [6:0]          cat_q;
    logic [3:0]          valor;
    logic                coincide;
    logic                blanco;

    assign an_q  = muestra_q[W-1:7];
    assign cat_q = muestra_q[6:0];

    segmentos_a_hex u_segmentos_a_hex (
        .catodos  (cat_q),
        .valor    (valor),
        .coincide (coincide),
        .blanco   (blanco)
    );

    logic          alguno;
    logic          varios;
    logic [IW-1:0] idx;

    // Anode scan: any digit selected, more than one selected, and which one
    always_comb begin
        alguno = 1'b0;
        varios = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            if (!an_q[k]) begin
                if (alguno) varios = 1'b1;
                alguno = 1'b1;
                idx    = IW'(k);
            end
        end
    end

    logic en_captura;
    logic acepta_valor;
    logic acepta_blanco;
    logic rechaza;

    assign en_captura    = (estado == S_CAPTURA);
    assign acepta_valor  = en_captura && alguno && !varios && coincide;
    assign acepta_blanco = en_captura && alguno && !varios && blanco;
    assign rechaza       = en_captura && alguno && (varios || (!coincide && !blanco));

    // Digit register file and result pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digito_o <= '0;
            valido_o <= '0;
            nuevo_o  <= 1'b0;
            error_o  <= 1'b0;
        end else begin
            nuevo_o <= acepta_valor || acepta_blanco;
            error_o <= rechaza;
            if (acepta_valor) begin
                digito_o[4*idx +: 4] <= valor;
                valido_o[idx]        <= 1'b1;
            end
            if (acepta_blanco) valido_o[idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_display_decodificador.sv
// Bench for display_decodificador (N_DIGITS=4, STABLE_CYCLES=4): reset checks,
// a table of held patterns, toggling, random dwells against a run-length
// reference model, and reset in the middle of a dwell.
module tb_display_decodificador;

    localparam int S = 4;
`ifdef DISPLAY_SYNC_EN
    localparam int D = 2;
`else
    localparam int D = 1;
`endif
    localparam int LAT = S + D + 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  catodos_i = '0;
    logic [3:0]  an_i = '0;
    logic [15:0] digito_o;
    logic [3:0]  valido_o;
    logic        nuevo_o;
    logic        error_o;

    display_decodificador #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .catodos_i (catodos_i),
        .an_i      (an_i),
        .digito_o  (digito_o),
        .valido_o  (valido_o),
        .nuevo_o   (nuevo_o),
        .error_o   (error_o)
    );

    always #5 clk = ~clk;

    logic [6:0] hex_tab [16];

    int n_tests = 0;
    int n_fail  = 0;
    int cnt_n   = 0;
    int cnt_e   = 0;

    // Reference model: a pattern held on the pins for S+1 consecutive edges is
    // applied D edges after its (S+1)-th sample, once per run.
    typedef struct {
        int          due;
        logic [10:0] pat;
    } pend_t;

    logic [15:0] m_dig;
    logic [3:0]  m_val;
    logic        m_nuevo;
    logic        m_err;
    logic [10:0] m_prev;
    bit          m_have;
    int          m_run;
    int          cyc;
    pend_t       m_q[$];

    function automatic void model_reset();
        m_dig   = '0;
        m_val   = '0;
        m_nuevo = 1'b0;
        m_err   = 1'b0;
        m_have  = 1'b0;
        m_run   = 0;
        m_q.delete();
    endfunction

    function automatic void model_apply(logic [10:0] pat);
        logic [3:0] an;
        logic [6:0] cat;
        int zeros;
        int k;
        int v;
        an    = pat[10:7];
        cat   = pat[6:0];
        zeros = 0;
        k     = 0;
        v     = -1;
        for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; k = i; end
        if (zeros == 0) return;
        if (zeros > 1) begin m_err = 1'b1; return; end
        for (int j = 0; j < 16; j++) if (hex_tab[j] == cat) v = j;
        if (v >= 0) begin
            m_dig[4*k +: 4] = 4'(v);
            m_val[k] = 1'b1;
            m_nuevo = 1'b1;
        end else if (cat == 7'b1111111) begin
            m_val[k] = 1'b0;
            m_nuevo = 1'b1;
        end else begin
            m_err = 1'b1;
        end
    endfunction

    function automatic void model_edge();
        logic [10:0] pat;
        cyc++;
        m_nuevo = 1'b0;
        m_err   = 1'b0;
        while (m_q.size() > 0 && m_q[0].due == cyc) begin
            model_apply(m_q[0].pat);
            void'(m_q.pop_front());
        end
        pat = {an_i, catodos_i};
        if (m_have && pat == m_prev) m_run++;
        else m_run = 1;
        m_prev = pat;
        m_have = 1'b1;
        if (m_run == S + 1) m_q.push_back('{cyc + D, pat});
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input logic [3:0] an, input logic [6:0] cat);
        an_i = an;
        catodos_i = cat;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_edge();
        #1;
        if (nuevo_o) cnt_n++;
        if (error_o) cnt_e++;
        check("model_digito", digito_o, m_dig);
        check("model_valido", 16'(valido_o), 16'(m_val));
        check("model_nuevo", 16'(nuevo_o), 16'(m_nuevo));
        check("model_error", 16'(error_o), 16'(m_err));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digito"}, digito_o, 16'h0);
        check({tag, "_valido"}, 16'(valido_o), 16'h0);
        check({tag, "_nuevo"}, 16'(nuevo_o), 16'h0);
        check({tag, "_error"}, 16'(error_o), 16'h0);
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) tick(4'($urandom), 7'($urandom));
        check_zero("reset");
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  an;
        logic [6:0]  cat;
        int          hold;
        logic [15:0] dig;
        logic [3:0]  val;
        int          n_nuevo;
        int          n_err;
    } vec_t;

    vec_t tab[12];

    initial begin
        logic [3:0] an;
        logic [6:0] cat;
        int first;

        hex_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

        tab[0]  = '{4'b1110, 7'b0010010, 12, 16'h0002, 4'b0001, 1, 0};
        tab[1]  = '{4'b1100, 7'b0000001, 10, 16'h0002, 4'b0001, 0, 1};
        tab[2]  = '{4'b1101, 7'b1111110, 10, 16'h0002, 4'b0001, 0, 1};
        tab[3]  = '{4'b1110, 7'b1001111,  8, 16'h0001, 4'b0001, 1, 0};
        tab[4]  = '{4'b1101, 7'b0010010,  8, 16'h0021, 4'b0011, 1, 0};
        tab[5]  = '{4'b1011, 7'b0000110,  8, 16'h0321, 4'b0111, 1, 0};
        tab[6]  = '{4'b0111, 7'b1001100,  8, 16'h4321, 4'b1111, 1, 0};
        tab[7]  = '{4'b1101, 7'b1111111,  8, 16'h4321, 4'b1101, 1, 0};
        tab[8]  = '{4'b1111, 7'b0000000,  8, 16'h4321, 4'b1101, 0, 0};
        tab[9]  = '{4'b0111, 7'b0111000,  8, 16'hF321, 4'b1101, 1, 0};
        tab[10] = '{4'b1011, 7'b0000110,  8, 16'hF321, 4'b1101, 1, 0};
        tab[11] = '{4'b1101, 7'b1100000, 20, 16'hF3B1, 4'b1111, 1, 0};

        cyc = 0;
        model_reset();

        // Reset with random inputs
        do_reset(3);

        // Held patterns
        for (int r = 0; r < 12; r++) begin
            cnt_n = 0;
            cnt_e = 0;
            for (int c = 0; c < tab[r].hold; c++) tick(tab[r].an, tab[r].cat);
            check($sformatf("row%0d_digito", r), digito_o, tab[r].dig);
            check($sformatf("row%0d_valido", r), 16'(valido_o), 16'(tab[r].val));
            check($sformatf("row%0d_nuevo_cnt", r), 16'(cnt_n), 16'(tab[r].n_nuevo));
            check($sformatf("row%0d_error_cnt", r), 16'(cnt_e), 16'(tab[r].n_err));
        end

        // Pattern toggling faster than qualification
        cnt_n = 0;
        cnt_e = 0;
        for (int t = 0; t < 10; t++)
            for (int c = 0; c < 3; c++) tick(4'b1110, (t % 2 == 0) ? 7'b0010010 : 7'b0000110);
        check("toggle_nuevo_cnt", 16'(cnt_n), 16'h0);
        check("toggle_error_cnt", 16'(cnt_e), 16'h0);
        check("toggle_digito", digito_o, 16'hF3B1);
        check("toggle_valido", 16'(valido_o), 16'hF);

        // Random dwells against the model
        for (int s = 0; s < 80; s++) begin
            int kind;
            int dwell;
            if (s == 40) do_reset(2);
            kind  = $urandom_range(0, 9);
            dwell = $urandom_range(1, 10);
            an    = ~(4'b0001 << $urandom_range(0, 3));
            cat   = hex_tab[$urandom_range(0, 15)];
            case (kind)
                6: cat = 7'b1111111;
                7: begin an = 4'b1111; cat = 7'($urandom); end
                8: an = ~((4'b0001 << $urandom_range(0, 1)) | (4'b0100 << $urandom_range(0, 1)));
                9: cat = 7'($urandom);
                default: ;
            endcase
            for (int c = 0; c < dwell; c++) tick(an, cat);
        end

        // Reset in the middle of a dwell
        tick(4'b1111, 7'b1111111);
        for (int c = 0; c < 3; c++) tick(4'b1110, 7'b0100100);
        rst_n = 1'b0;
        #1;
        check_zero("midreset_async");
        tick(4'b1110, 7'b0100100);
        tick(4'b1110, 7'b0100100);
        rst_n = 1'b1;
        first = 0;
        for (int c = 1; c <= LAT + 4; c++) begin
            tick(4'b1110, 7'b0100100);
            if (nuevo_o && first == 0) first = c;
        end
        check("midreset_latency", 16'(first), 16'(LAT));
        check("midreset_digito", digito_o, 16'h0005);
        check("midreset_valido", 16'(valido_o), 16'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
